// File: rtl/input_conditioner.sv
// Synchronises, debounces and edge-detects an asynchronous single-bit input.
// Debounce FSM and counter are compiled in only when INPUT_COND_DEBOUNCE_EN is defined.
module input_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic glitch_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  // Plain flop chain into the clk domain; s is the last stage
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_async_i};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef INPUT_COND_DEBOUNCE_EN

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             level_d, rise_d, fall_d, glitch_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STABLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state; an accepted value always lands back in STABLE with a fresh count
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    level_d  = level_o;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (s != level_o) begin
          if (DEBOUNCE_CYCLES == 1) begin
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
            count_d = '0;
          end else begin
            state_d = ST_PENDING;
            count_d = CNT_W'(1);
          end
        end
      end
      ST_PENDING: begin
        if (s == level_o) begin
          state_d  = ST_STABLE;
          count_d  = '0;
          glitch_d = 1'b1;
        end else if (count_q == CNT_LAST) begin
          state_d = ST_STABLE;
          count_d = '0;
          level_d = s;
          rise_d  = s;
          fall_d  = ~s;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_o  <= RESET_LEVEL;
      rise_o   <= 1'b0;
      fall_o   <= 1'b0;
      glitch_o <= 1'b0;
    end else begin
      level_o  <= level_d;
      rise_o   <= rise_d;
      fall_o   <= fall_d;
      glitch_o <= glitch_d;
    end
  end

`else

  // Without debounce the level simply follows s one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_o <= RESET_LEVEL;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      level_o <= s;
      rise_o  <= s & ~level_o;
      fall_o  <= ~s & level_o;
    end
  end

  assign glitch_o = 1'b0;

`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner (default parameters); follows INPUT_COND_DEBOUNCE_EN.
module tb_input_conditioner;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
`ifdef INPUT_COND_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
  localparam int LAT    = SYNC + DEB - 1;
`else
  localparam bit DEB_EN = 1'b0;
  localparam int LAT    = SYNC;
`endif
  localparam int HN = 512;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic glitch;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic d_async_i = 1'b0;
  logic level_o, rise_o, fall_o, glitch_o;

  input_conditioner dut (
    .clk       (clk),
    .reset     (reset),
    .d_async_i (d_async_i),
    .level_o   (level_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .glitch_o  (glitch_o)
  );

  always #5 clk = ~clk;

  obs_t            exp_q[$];
  obs_t            hist[HN];
  logic [SYNC-1:0] m_sync;
  logic            m_level;
  int              m_run;
  int              edge_n;
  int              n_tests = 0;
  int              n_fail  = 0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Reference: run length of consecutive sampled values differing from the level
  task automatic model_edge(input logic d);
    obs_t e;
    logic s_old;
    e     = '0;
    s_old = m_sync[SYNC-1];
    if (DEB_EN) begin
      if (s_old != m_level) begin
        if (m_run + 1 >= int'(DEB)) begin
          m_level = s_old;
          e.rise  = s_old;
          e.fall  = !s_old;
          m_run   = 0;
        end else begin
          m_run++;
        end
      end else begin
        e.glitch = (m_run > 0);
        m_run    = 0;
      end
    end else begin
      e.rise  = s_old && !m_level;
      e.fall  = !s_old && m_level;
      m_level = s_old;
    end
    m_sync  = {m_sync[SYNC-2:0], d};
    e.level = m_level;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic d);
    obs_t cur, e;
    d_async_i = d;
    model_edge(d);
    @(posedge clk);
    #1;
    edge_n++;
    cur = {level_o, rise_o, fall_o, glitch_o};
    if (edge_n < HN) hist[edge_n] = cur;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_empty: got %b at edge %0d, expected a queued entry", cur, edge_n);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("sb_edge%0d", edge_n), cur, e);
    end
  endtask

  // Called between edges: asserts reset, checks outputs clear before the next edge
  task automatic do_reset(input logic d);
    d_async_i = d;
    reset = 1'b1;
    #1;
    check("rst_outputs", {level_o, rise_o, fall_o, glitch_o}, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    m_sync  = '0;
    m_level = 1'b0;
    m_run   = 0;
    exp_q.delete();
    for (int i = 0; i < HN; i++) hist[i] = '0;
    edge_n = 0;
    reset  = 1'b0;
  endtask

  function automatic int count_rise(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(hist[i].rise);
    return c;
  endfunction

  function automatic int count_glitch(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(hist[i].glitch);
    return c;
  endfunction

  function automatic int count_level(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(hist[i].level);
    return c;
  endfunction

  initial begin
    #2;
    do_reset(1'b0);

    // Clean rise captured at edge 10
    for (int e = 1; e <= 25; e++) step(e >= 10);
    check("rise_before", {3'b000, hist[9+LAT].level}, 4'b0000);
    check("rise_edge",   {2'b00, hist[10+LAT].level, hist[10+LAT].rise}, 4'b0011);
    check("rise_once",   {3'b000, hist[11+LAT].rise}, 4'b0000);
    check("rise_noglt",  4'(count_glitch(1, 25)), 4'd0);

    // Input high only at capture edges 10-11
    do_reset(1'b0);
    for (int e = 1; e <= 25; e++) step(e == 10 || e == 11);
`ifdef INPUT_COND_DEBOUNCE_EN
    check("short_glitch", {2'b00, hist[13].glitch, hist[14].glitch}, 4'b0001);
    check("short_level",  4'(count_level(1, 25)), 4'd0);
    check("short_norise", 4'(count_rise(1, 25)), 4'd0);
`else
    check("short_rise",   {3'b000, hist[12].rise}, 4'b0001);
    check("short_fall",   {3'b000, hist[14].fall}, 4'b0001);
    check("short_noglt",  4'(count_glitch(1, 25)), 4'd0);
`endif

    // Three captured cycles from edge 10, then four from edge 20
    do_reset(1'b0);
    for (int e = 1; e <= 35; e++) step((e >= 10 && e <= 12) || (e >= 20 && e <= 23));
`ifdef INPUT_COND_DEBOUNCE_EN
    check("bnd3_glitch", {3'b000, hist[15].glitch}, 4'b0001);
    check("bnd3_level",  4'(count_level(1, 24)), 4'd0);
    check("bnd4_rise",   {2'b00, hist[25].level, hist[25].rise}, 4'b0011);
    check("bnd4_hold",   {3'b000, hist[28].level}, 4'b0001);
    check("bnd4_fall",   {2'b00, hist[29].level, hist[29].fall}, 4'b0001);
    check("bnd_rises",   4'(count_rise(1, 35)), 4'd1);
`else
    check("bnd_rise1",   {3'b000, hist[12].rise}, 4'b0001);
    check("bnd_fall1",   {3'b000, hist[15].fall}, 4'b0001);
    check("bnd_rise2",   {3'b000, hist[22].rise}, 4'b0001);
    check("bnd_fall2",   {3'b000, hist[26].fall}, 4'b0001);
`endif

    // Clean fall captured at edge 30
    do_reset(1'b0);
    for (int e = 1; e <= 40; e++) step(e < 30);
    check("fall_before", {3'b000, hist[29+LAT].level}, 4'b0001);
    check("fall_edge",   {2'b00, hist[30+LAT].level, hist[30+LAT].fall}, 4'b0001);

    // Async reset with level high and input held high
    for (int e = 1; e <= 12; e++) step(1'b1);
    check("pre_rst_level", {3'b000, level_o}, 4'b0001);
    do_reset(1'b1);
    for (int e = 1; e <= 10; e++) step(1'b1);
    check("post_rst_before", {3'b000, hist[LAT].level}, 4'b0000);
    check("post_rst_rise",   {2'b00, hist[1+LAT].level, hist[1+LAT].rise}, 4'b0011);

    // Bouncy random input, scoreboard only, with a reset dropped in mid-stream
    do_reset(1'b0);
    for (int b = 0; b < 120; b++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) step(v);
      if (b == 60) do_reset(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioner for an asynchronous, possibly bouncing single-bit input (pushbutton, external strobe, off-chip status line). It synchronises the input into the `clk` domain, debounces it, and produces a clean registered level plus single-cycle rise and fall pulses. It sits directly upstream of the team's flop and reset stages, and its `level_o` output is the clean `d_i`-style signal those stages capture.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth; legal values ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised cycles a new value must hold before it is accepted; legal values ≥ 1.
- `RESET_LEVEL`, default 1'b0: value loaded into the synchroniser flops and `level_o` at reset.

Ports:
- `clk`  in  1  clock; all flops are rising-edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `d_async_i`  in  1  raw asynchronous input.
- `level_o`  out  1  debounced, registered level.
- `rise_o`  out  1  one-cycle pulse on an accepted 0→1 transition.
- `fall_o`  out  1  one-cycle pulse on an accepted 1→0 transition.
- `glitch_o`  out  1  one-cycle pulse when a pending transition is aborted.

## Operation
- **Synchroniser**
  - `SYNC_STAGES` flops in a chain; the last stage is `s`.
  - No logic between the stages.
- **Debounce FSM** has two states:
  - STABLE: `s == level_o`, count = 0.
  - PENDING: `s` has differed from `level_o` on one or more consecutive edges.
- **Counter**
  - Width `max(1, $clog2(DEBOUNCE_CYCLES))`; it holds at most `DEBOUNCE_CYCLES-1`.
  - It never wraps.
- **Per-edge rules**
  - STABLE with `s != level_o`:
    - If `DEBOUNCE_CYCLES == 1`, accept immediately.
    - Otherwise go to PENDING with count = 1.
  - PENDING with `s != level_o` and count+1 == `DEBOUNCE_CYCLES`: accept.
  - PENDING with `s != level_o` otherwise: count increments.
  - PENDING with `s == level_o`: return to STABLE, count = 0, `glitch_o` = 1 for one cycle.
  - Accept: `level_o <= s`, go to STABLE, count = 0, `rise_o` or `fall_o` = 1 for one cycle (according to the new value).
- **Output behaviour**
  - All outputs come directly from flops.
  - `rise_o`/`fall_o` go high in the same cycle as the first cycle of the new `level_o`.
  - `rise_o`, `fall_o` and `glitch_o` are mutually exclusive.
  - Back-to-back accepted transitions are legal and each produces its own pulse.
- **Reset values**
  - Synchroniser flops and `level_o` = `RESET_LEVEL`.
  - State = STABLE, count = 0.
  - `rise_o` = `fall_o` = `glitch_o` = 0.
- **Reset mid-operation**
  - All flops are forced to their reset values asynchronously.
  - A pending transition is discarded with no pulse.
  - After deassertion, if `d_async_i` ≠ `RESET_LEVEL`, it is processed as a new transition.

## Timing
- Let edge k be the first rising edge at which the synchroniser's first stage captures a new value.
  - `s` changes after edge k+`SYNC_STAGES`-1.
  - `level_o` changes after edge k+`SYNC_STAGES`+`DEBOUNCE_CYCLES`-1. With defaults this is k+5.
- Glitch timing: when `s` returns to `level_o` before the transition is accepted, `glitch_o` is high for the cycle following the edge at which the FSM samples the returned value.
- Throughput: one accepted transition per `DEBOUNCE_CYCLES` cycles at most.

## Configuration
- `INPUT_COND_DEBOUNCE_EN` defined:
  - The debounce FSM and counter are compiled in, as described above.
- Not defined:
  - The FSM and counter are removed and `DEBOUNCE_CYCLES` is ignored.
  - `level_o` is a register of `s`, i.e. it changes after edge k+`SYNC_STAGES`.
  - `rise_o` and `fall_o` are still generated from the change of `level_o`.
  - `glitch_o` is tied to 0.

## Test plan
All scenarios use default parameters unless stated.
- **Async reset:** `d_async_i`=1 and `level_o`=1 steady, assert `reset` between edges → all outputs 0 before the next edge. Deassert with `d_async_i`=1 → `level_o` rises 5 edges after the first capture edge.
- **Clean rise:** `d_async_i` 0→1, first captured at edge 10 → `level_o`=1 after edge 15; `rise_o` high only in the cycle after edge 15; `glitch_o` stays 0.
- **Short glitch:** `d_async_i` high only at capture edges 10–11 → `level_o` stays 0, `glitch_o` high only in the cycle after edge 14, no `rise_o`.
- **Boundary:**
  - High for exactly 3 captured cycles from edge 10 → no transition; `glitch_o` pulses after edge 15.
  - High for exactly 4 captured cycles from edge 20 → `rise_o` after edge 25, `fall_o` after edge 29.
- **Clean fall:** `level_o`=1, `d_async_i` 1→0, captured at edge 30 → `level_o`=0 and `fall_o` pulse after edge 35.
- **Macro off:** `d_async_i` 0→1, captured at edge 10 → `level_o`=1 and `rise_o` after edge 12. A 1-cycle glitch produces a `rise_o`/`fall_o` pair; `glitch_o` is never asserted.
